// File: rtl/bcd_down_timer_if.sv
// bcd_down_timer_if: control, data and status bundle of the multi-digit BCD down timer.
//   master : drives load/start/stop/ce/data, observes count/ceo/tc/busy/done/error
//   slave  : the timer itself
// Parameter DIGITS sets the packed width of data/count (4*DIGITS).
interface bcd_down_timer_if #(
  parameter int DIGITS = 4
);
  logic                  load;
  logic                  start;
  logic                  stop;
  logic                  ce;
  logic [4*DIGITS-1:0]   data;
  logic [4*DIGITS-1:0]   count;
  logic                  ceo;
  logic                  tc;
  logic                  busy;
  logic                  done;
  logic                  error;

  modport master (
    output load, start, stop, ce, data,
    input  count, ceo, tc, busy, done, error
  );

  modport slave (
    input  load, start, stop, ce, data,
    output count, ceo, tc, busy, done, error
  );
endinterface

// File: rtl/bcd_down_timer.sv
// bcd_down_timer: parametrised multi-digit down-counting timer.
//   clk    : rising-edge clock
//   reset  : synchronous, active-low reset
//   bus    : bcd_down_timer_if.slave
//            load/start/stop/ce/data in; count/ceo/tc/busy/done/error out
// Parameters: DIGITS (4-bit digits), DIGIT_MAX (per-digit maximum, 1..15).
// Optional feature macro TIMER_RELOAD_EN: periodic mode with a reload
// register; the default build is a one-shot timer.

// Per-digit lane: decremented value of one digit and load-data range check.
module bcd_digit_lane #(
  parameter int DIGIT_MAX = 9
) (
  input  logic [3:0] cur,
  input  logic       step,
  input  logic [3:0] ld,
  output logic [3:0] nxt,
  output logic       ld_bad
);
  localparam logic [3:0] DMAX = 4'(DIGIT_MAX);

  always_comb begin
    nxt = cur;
    if (step) nxt = (cur == 4'd0) ? DMAX : cur - 4'd1;
  end

  assign ld_bad = (ld > DMAX);
endmodule

module bcd_down_timer #(
  parameter int DIGITS    = 4,
  parameter int DIGIT_MAX = 9
) (
  input  logic            clk,
  input  logic            reset,
  bcd_down_timer_if.slave bus
);
  localparam int W = 4 * DIGITS;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t                   state_q, state_d;
  logic [DIGITS-1:0][3:0]   cnt_q, cnt_d, cnt_dec, ld_dig;
  logic [DIGITS-1:0]        step, ld_bad;
  logic                     err_q, err_d;
  logic                     tc_q, tc_d;
  logic [W-1:0]             cnt_flat;
  logic                     cnt_zero, cnt_one;

  assign ld_dig   = bus.data;
  assign cnt_flat = cnt_q;
  assign cnt_zero = (cnt_flat == '0);
  assign cnt_one  = (cnt_flat == W'(1));

  // Borrow chain: digit i steps only when every lower digit is zero.
  // Built from cnt_q directly so there is no comb loop through the lanes.
  always_comb begin
    step[0] = 1'b1;
    for (int i = 1; i < DIGITS; i++)
      step[i] = step[i-1] & (cnt_q[i-1] == 4'd0);
  end

  for (genvar g = 0; g < DIGITS; g++) begin : g_lane
    bcd_digit_lane #(.DIGIT_MAX(DIGIT_MAX)) u_lane (
      .cur    (cnt_q[g]),
      .step   (step[g]),
      .ld     (ld_dig[g]),
      .nxt    (cnt_dec[g]),
      .ld_bad (ld_bad[g])
    );
  end

`ifdef TIMER_RELOAD_EN
  logic [W-1:0] rld_q, rld_d;
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
    tc_d    = 1'b0;
`ifdef TIMER_RELOAD_EN
    rld_d   = rld_q;
`endif
    if (bus.load) begin
      state_d = S_IDLE;
      if (|ld_bad) begin
        err_d = 1'b1;
        cnt_d = '0;
      end else begin
        err_d = 1'b0;
        cnt_d = bus.data;
`ifdef TIMER_RELOAD_EN
        rld_d = bus.data;
`endif
      end
    end else begin
      unique case (state_q)
        S_IDLE: begin
          // ce is ignored here even alongside start: counting begins next cycle.
          if (!bus.stop && bus.start) begin
            if (cnt_zero) begin
              tc_d = 1'b1;
`ifdef TIMER_RELOAD_EN
              // Periodic mode never parks in DONE; a zero start just runs.
              state_d = S_RUN;
`else
              state_d = S_DONE;
`endif
            end else begin
              state_d = S_RUN;
            end
          end
        end
        S_RUN: begin
          if (bus.stop) begin
            state_d = S_IDLE;
          end else if (bus.ce) begin
            if (cnt_zero) begin
`ifdef TIMER_RELOAD_EN
              // Reload tick; a zero reload value keeps tc pulsing every ce.
              cnt_d = rld_q;
              tc_d  = (rld_q == '0);
`else
              state_d = S_DONE;
`endif
            end else begin
              cnt_d = cnt_dec;
              if (cnt_one) begin
                tc_d = 1'b1;
`ifndef TIMER_RELOAD_EN
                state_d = S_DONE;
`endif
              end
            end
          end
        end
        S_DONE: ;
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      err_q   <= 1'b0;
      tc_q    <= 1'b0;
`ifdef TIMER_RELOAD_EN
      rld_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
      tc_q    <= tc_d;
`ifdef TIMER_RELOAD_EN
      rld_q   <= rld_d;
`endif
    end
  end

  assign bus.count = cnt_q;
  assign bus.tc    = tc_q;
  assign bus.error = err_q;
  assign bus.busy  = (state_q == S_RUN);
  assign bus.ceo   = bus.ce & (state_q == S_RUN) & cnt_one;
`ifdef TIMER_RELOAD_EN
  assign bus.done  = 1'b0;
`else
  assign bus.done  = (state_q == S_DONE);
`endif
endmodule

// File: tb/tb_bcd_down_timer.sv
// tb_bcd_down_timer: directed bench for bcd_down_timer (DIGITS=4, DIGIT_MAX=9)
// plus a DIGIT_MAX=5 instance for the wrap-to-max case. Expectations follow
// TIMER_RELOAD_EN when the bench is built with that macro.
module tb_bcd_down_timer;
  logic clk = 1'b0;
  logic reset;
  int   vecs = 0;
  int   errs = 0;

  bcd_down_timer_if #(.DIGITS(4)) bus ();
  bcd_down_timer_if #(.DIGITS(4)) bus5 ();

  bcd_down_timer #(.DIGITS(4), .DIGIT_MAX(9)) u_dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  bcd_down_timer #(.DIGITS(4), .DIGIT_MAX(5)) u_dut5 (
    .clk   (clk),
    .reset (reset),
    .bus   (bus5.slave)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic ld, input logic st, input logic sp, input logic c,
                       input logic [15:0] d);
    bus.load = ld; bus.start = st; bus.stop = sp; bus.ce = c; bus.data = d;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    drive(1'b1, 1'b0, 1'b0, 1'b0, 16'h1234);
    bus5.load = 1'b1; bus5.start = 1'b0; bus5.stop = 1'b0; bus5.ce = 1'b0; bus5.data = 16'h1234;
    tick(); tick();
    vecs++; if (bus.count !== 16'h0000) begin errs++; $display("FAIL rst_count got %h exp 0000", bus.count); end
    vecs++; if (bus.tc !== 1'b0)    begin errs++; $display("FAIL rst_tc got %b exp 0", bus.tc); end
    vecs++; if (bus.busy !== 1'b0)  begin errs++; $display("FAIL rst_busy got %b exp 0", bus.busy); end
    vecs++; if (bus.done !== 1'b0)  begin errs++; $display("FAIL rst_done got %b exp 0", bus.done); end
    vecs++; if (bus.error !== 1'b0) begin errs++; $display("FAIL rst_error got %b exp 0", bus.error); end
    vecs++; if (bus5.count !== 16'h0000) begin errs++; $display("FAIL rst_count5 got %h exp 0000", bus5.count); end
    reset = 1'b1;
    drive(1'b0, 1'b0, 1'b0, 1'b0, 16'h0000);
    bus5.load = 1'b0;
    tick();
  endtask

  task automatic test_countdown();
    drive(1'b1, 1'b0, 1'b0, 1'b0, 16'h0102); tick();
    drive(1'b0, 1'b1, 1'b0, 1'b1, 16'h0000); tick();
    vecs++; if (bus.count !== 16'h0102) begin errs++; $display("FAIL start_nodec got %h exp 0102", bus.count); end
    vecs++; if (bus.busy !== 1'b1) begin errs++; $display("FAIL start_busy got %b exp 1", bus.busy); end
    drive(1'b0, 1'b0, 1'b0, 1'b1, 16'h0000); tick();
    vecs++; if (bus.count !== 16'h0101) begin errs++; $display("FAIL dec_0101 got %h exp 0101", bus.count); end
    tick();
    vecs++; if (bus.count !== 16'h0100) begin errs++; $display("FAIL dec_0100 got %h exp 0100", bus.count); end
    tick();
    vecs++; if (bus.count !== 16'h0099) begin errs++; $display("FAIL dec_0099 got %h exp 0099", bus.count); end
    vecs++; if (bus.ceo !== 1'b0) begin errs++; $display("FAIL ceo_early got %b exp 0", bus.ceo); end
    for (int i = 0; i < 98; i++) tick();
    vecs++; if (bus.count !== 16'h0001) begin errs++; $display("FAIL dec_0001 got %h exp 0001", bus.count); end
    vecs++; if (bus.ceo !== 1'b1) begin errs++; $display("FAIL ceo_102 got %b exp 1", bus.ceo); end
    vecs++; if (bus.tc !== 1'b0) begin errs++; $display("FAIL tc_pre got %b exp 0", bus.tc); end
    tick();
    vecs++; if (bus.count !== 16'h0000) begin errs++; $display("FAIL zero got %h exp 0000", bus.count); end
    vecs++; if (bus.tc !== 1'b1) begin errs++; $display("FAIL tc_pulse got %b exp 1", bus.tc); end
`ifdef TIMER_RELOAD_EN
    vecs++; if (bus.busy !== 1'b1) begin errs++; $display("FAIL rl_busy got %b exp 1", bus.busy); end
    vecs++; if (bus.done !== 1'b0) begin errs++; $display("FAIL rl_done got %b exp 0", bus.done); end
    tick();
    vecs++; if (bus.count !== 16'h0102) begin errs++; $display("FAIL rl_reload got %h exp 0102", bus.count); end
`else
    vecs++; if (bus.done !== 1'b1) begin errs++; $display("FAIL done got %b exp 1", bus.done); end
    vecs++; if (bus.busy !== 1'b0) begin errs++; $display("FAIL done_busy got %b exp 0", bus.busy); end
    tick();
    vecs++; if (bus.count !== 16'h0000) begin errs++; $display("FAIL done_hold got %h exp 0000", bus.count); end
    vecs++; if (bus.done !== 1'b1) begin errs++; $display("FAIL done_stay got %b exp 1", bus.done); end
`endif
    vecs++; if (bus.tc !== 1'b0) begin errs++; $display("FAIL tc_one_cycle got %b exp 0", bus.tc); end
    drive(1'b0, 1'b0, 1'b0, 1'b0, 16'h0000);
  endtask

  task automatic test_error();
    drive(1'b1, 1'b0, 1'b0, 1'b0, 16'h00A3); tick();
    vecs++; if (bus.error !== 1'b1) begin errs++; $display("FAIL err_set got %b exp 1", bus.error); end
    vecs++; if (bus.count !== 16'h0000) begin errs++; $display("FAIL err_count got %h exp 0000", bus.count); end
    vecs++; if (bus.busy !== 1'b0) begin errs++; $display("FAIL err_idle got %b exp 0", bus.busy); end
    drive(1'b0, 1'b1, 1'b0, 1'b0, 16'h0000); tick();
    vecs++; if (bus.tc !== 1'b1) begin errs++; $display("FAIL err_start_tc got %b exp 1", bus.tc); end
    vecs++; if (bus.error !== 1'b1) begin errs++; $display("FAIL err_sticky got %b exp 1", bus.error); end
`ifndef TIMER_RELOAD_EN
    vecs++; if (bus.done !== 1'b1) begin errs++; $display("FAIL err_start_done got %b exp 1", bus.done); end
`endif
    drive(1'b1, 1'b0, 1'b0, 1'b0, 16'h0005); tick();
    vecs++; if (bus.error !== 1'b0) begin errs++; $display("FAIL err_clear got %b exp 0", bus.error); end
    vecs++; if (bus.count !== 16'h0005) begin errs++; $display("FAIL err_reload got %h exp 0005", bus.count); end
    vecs++; if (bus.done !== 1'b0) begin errs++; $display("FAIL err_done_exit got %b exp 0", bus.done); end
    drive(1'b0, 1'b0, 1'b0, 1'b0, 16'h0000);
  endtask

  task automatic test_stop();
    drive(1'b1, 1'b0, 1'b0, 1'b0, 16'h0050); tick();
    drive(1'b0, 1'b1, 1'b0, 1'b0, 16'h0000); tick();
    drive(1'b0, 1'b0, 1'b1, 1'b1, 16'h0000); tick();
    vecs++; if (bus.busy !== 1'b0) begin errs++; $display("FAIL stop_busy got %b exp 0", bus.busy); end
    vecs++; if (bus.count !== 16'h0050) begin errs++; $display("FAIL stop_ce got %h exp 0050", bus.count); end
    drive(1'b0, 1'b0, 1'b0, 1'b1, 16'h0000);
    vecs++; if (bus.ceo !== 1'b0) begin errs++; $display("FAIL ceo_idle got %b exp 0", bus.ceo); end
    for (int i = 0; i < 10; i++) tick();
    vecs++; if (bus.count !== 16'h0050) begin errs++; $display("FAIL stop_hold got %h exp 0050", bus.count); end
    drive(1'b0, 1'b1, 1'b0, 1'b1, 16'h0000); tick();
    vecs++; if (bus.count !== 16'h0050) begin errs++; $display("FAIL resume_nodec got %h exp 0050", bus.count); end
    drive(1'b0, 1'b0, 1'b0, 1'b1, 16'h0000); tick();
    vecs++; if (bus.count !== 16'h0049) begin errs++; $display("FAIL resume_0049 got %h exp 0049", bus.count); end
    drive(1'b0, 1'b0, 1'b0, 1'b0, 16'h0000);
  endtask

  task automatic test_load_override();
    drive(1'b1, 1'b0, 1'b0, 1'b0, 16'h0020); tick();
    drive(1'b0, 1'b1, 1'b0, 1'b0, 16'h0000); tick();
    drive(1'b0, 1'b0, 1'b0, 1'b1, 16'h0000); tick();
    vecs++; if (bus.count !== 16'h0019) begin errs++; $display("FAIL ovr_run got %h exp 0019", bus.count); end
    drive(1'b1, 1'b1, 1'b0, 1'b1, 16'h0007); tick();
    vecs++; if (bus.count !== 16'h0007) begin errs++; $display("FAIL ovr_load got %h exp 0007", bus.count); end
    vecs++; if (bus.busy !== 1'b0) begin errs++; $display("FAIL ovr_idle got %b exp 0", bus.busy); end
    drive(1'b0, 1'b0, 1'b0, 1'b1, 16'h0000); tick();
    vecs++; if (bus.count !== 16'h0007) begin errs++; $display("FAIL ovr_ce_idle got %h exp 0007", bus.count); end
    drive(1'b0, 1'b0, 1'b0, 1'b0, 16'h0000);
  endtask

  task automatic test_digit_max5();
    bus5.load = 1'b1; bus5.data = 16'h0100; tick();
    bus5.load = 1'b0; bus5.start = 1'b1; tick();
    bus5.start = 1'b0; bus5.ce = 1'b1; tick();
    bus5.ce = 1'b0;
    vecs++; if (bus5.count !== 16'h0055) begin errs++; $display("FAIL max5_wrap got %h exp 0055", bus5.count); end
  endtask

`ifdef TIMER_RELOAD_EN
  task automatic test_reload();
    drive(1'b1, 1'b0, 1'b0, 1'b0, 16'h0003); tick();
    drive(1'b0, 1'b1, 1'b0, 1'b0, 16'h0000); tick();
    drive(1'b0, 1'b0, 1'b0, 1'b1, 16'h0000); tick();
    vecs++; if (bus.count !== 16'h0002) begin errs++; $display("FAIL rl_2 got %h exp 0002", bus.count); end
    tick();
    vecs++; if (bus.count !== 16'h0001) begin errs++; $display("FAIL rl_1 got %h exp 0001", bus.count); end
    vecs++; if (bus.ceo !== 1'b1) begin errs++; $display("FAIL rl_ceo got %b exp 1", bus.ceo); end
    tick();
    vecs++; if (bus.count !== 16'h0000) begin errs++; $display("FAIL rl_0 got %h exp 0000", bus.count); end
    vecs++; if (bus.tc !== 1'b1) begin errs++; $display("FAIL rl_tc got %b exp 1", bus.tc); end
    vecs++; if (bus.ceo !== 1'b0) begin errs++; $display("FAIL rl_ceo_reload got %b exp 0", bus.ceo); end
    tick();
    vecs++; if (bus.count !== 16'h0003) begin errs++; $display("FAIL rl_3 got %h exp 0003", bus.count); end
    vecs++; if (bus.busy !== 1'b1) begin errs++; $display("FAIL rl_busy_keep got %b exp 1", bus.busy); end
    vecs++; if (bus.tc !== 1'b0) begin errs++; $display("FAIL rl_tc_off got %b exp 0", bus.tc); end
    drive(1'b0, 1'b0, 1'b0, 1'b0, 16'h0000);
  endtask
`endif

  initial begin
    drive(1'b0, 1'b0, 1'b0, 1'b0, 16'h0000);
    bus5.load = 1'b0; bus5.start = 1'b0; bus5.stop = 1'b0; bus5.ce = 1'b0; bus5.data = 16'h0000;
    reset = 1'b1;
    test_reset();
    test_countdown();
    test_error();
    test_stop();
    test_load_override();
    test_digit_max5();
`ifdef TIMER_RELOAD_EN
    test_reload();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
